// File: rtl/hapara_icap_pkg.sv
// Shared types, ICAP command words and sequence helpers for the ICAPE2 readback engine.
// Word-level helpers return ICAP-native order; bit reordering is applied by the top.
package hapara_icap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_SW_RD,
      ST_READ,
      ST_SW_WR,
      ST_DSYNC,
      ST_DONE
   } rb_state_e;

   localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
   localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
   localparam logic [31:0] ICAP_NOOP       = 32'h2000_0000;
   localparam logic [31:0] ICAP_WR_CMD     = 32'h3000_8001;
   localparam logic [31:0] ICAP_CMD_RCFG   = 32'h0000_0004;
   localparam logic [31:0] ICAP_CMD_DESYNC = 32'h0000_000D;
   localparam logic [31:0] ICAP_WR_FAR     = 32'h3000_2001;
   localparam logic [31:0] ICAP_RD_FDRO    = 32'h2800_6000;
   localparam logic [31:0] ICAP_T2_RD      = 32'h4800_0000;

   localparam int HDR_LEN   = 12;
   localparam int DSYNC_LEN = 4;

   // Readback preamble: sync, RCFG command, FAR write, then a type-2 FDRO read of word_cnt words.
   function automatic logic [31:0] hdr_word(input logic [3:0]  idx,
                                            input logic [31:0] far_v,
                                            input logic [26:0] cnt_v);
      logic [31:0] w;
      case (idx)
         4'd0:    w = ICAP_DUMMY;
         4'd1:    w = ICAP_SYNC;
         4'd4:    w = ICAP_WR_CMD;
         4'd5:    w = ICAP_CMD_RCFG;
         4'd7:    w = ICAP_WR_FAR;
         4'd8:    w = far_v;
         4'd9:    w = ICAP_RD_FDRO;
         4'd10:   w = ICAP_T2_RD | {5'b0, cnt_v};
         default: w = ICAP_NOOP;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] dsync_word(input logic [1:0] idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = ICAP_WR_CMD;
         2'd1:    w = ICAP_CMD_DESYNC;
         default: w = ICAP_NOOP;
      endcase
      return w;
   endfunction

   // Reverses the bit order inside each byte; byte positions are unchanged.
   function automatic logic [31:0] bitswap_bytes(input logic [31:0] w);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            r[8*b + i] = w[8*b + 7 - i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hapara_icap_readback_if.sv
// Valid/ready stream carrying readback words from the engine to its consumer.
interface hapara_icap_readback_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/hapara_icap_rb_fifo.sv
// Synchronous FIFO buffering readback words; upstream admission control guarantees no overflow.
module hapara_icap_rb_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         pop_data,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          empty
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  do_pop;

   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; validity is tracked by the pointers
   // and count alone, which keeps the array mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/hapara_icap_readback.sv
// ICAPE2 configuration readback engine: header, flow-controlled FDRO reads, DESYNC.
// Build with HAPARA_ICAP_BITSWAP_EN to reverse bits within each byte on icap_i and icap_o.
module hapara_icap_readback
   import hapara_icap_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int READ_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           far,
   input  logic [26:0]           word_cnt,
   output logic                  busy,
   output logic                  done,
   output logic                  icap_csib,
   output logic                  icap_rdwrb,
   output logic [DATA_WIDTH-1:0] icap_i,
   input  logic [DATA_WIDTH-1:0] icap_o,
   hapara_icap_readback_if.master m
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0] HDR_LAST   = 4'(HDR_LEN - 1);
   localparam logic [3:0] DSYNC_LAST = 4'(DSYNC_LEN - 1);

`ifdef HAPARA_ICAP_BITSWAP_EN
   localparam bit BITSWAP = 1'b1;
`else
   localparam bit BITSWAP = 1'b0;
`endif

   function automatic logic [31:0] to_icap(input logic [31:0] w);
      return BITSWAP ? bitswap_bytes(w) : w;
   endfunction

   rb_state_e               state;
   logic [3:0]              idx;
   logic [31:0]             far_q;
   logic [26:0]             rem;
   logic [READ_LATENCY-1:0] inflight;

   logic                    issue_cur;
   logic                    issue_next;
   logic [31:0]             committed;
   logic                    m_valid_int;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty;
   logic [DATA_WIDTH-1:0]   fifo_rdata;

   // Admission counts every word already owed a FIFO slot: buffered, in the ICAP pipe,
   // and the read being issued this cycle. Pops are ignored, so this never over-commits.
   always_comb begin
      issue_cur  = (state == ST_READ) && !icap_csib;
      committed  = 32'(fifo_count) + 32'($countones(inflight)) + 32'(issue_cur);
      issue_next = (rem != '0) && (committed < 32'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         far_q      <= '0;
         rem        <= '0;
         inflight   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         icap_csib  <= 1'b1;
         icap_rdwrb <= 1'b0;
         icap_i     <= '0;
      end else begin
         inflight <= (inflight << 1) | READ_LATENCY'(issue_cur);
         done     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_HDR;
                  idx        <= '0;
                  far_q      <= far;
                  rem        <= word_cnt;
                  busy       <= 1'b1;
                  icap_csib  <= 1'b0;
                  icap_rdwrb <= 1'b0;
                  icap_i     <= to_icap(hdr_word(4'd0, far, word_cnt));
               end
            end

            ST_HDR: begin
               if (idx == HDR_LAST) begin
                  // Deselect while the direction flips so rdwrb never moves under csib=0.
                  state      <= ST_SW_RD;
                  icap_csib  <= 1'b1;
                  icap_rdwrb <= 1'b1;
                  icap_i     <= '0;
               end else begin
                  idx    <= idx + 4'd1;
                  icap_i <= to_icap(hdr_word(idx + 4'd1, far_q, rem));
               end
            end

            // SW_RD shares READ's logic: with nothing to fetch it leaves straight for SW_WR.
            ST_SW_RD, ST_READ: begin
               if ((rem == '0) && !issue_cur && (inflight == '0)) begin
                  state      <= ST_SW_WR;
                  icap_csib  <= 1'b1;
                  icap_rdwrb <= 1'b0;
               end else begin
                  state     <= ST_READ;
                  icap_csib <= !issue_next;
                  rem       <= rem - 27'(issue_next);
               end
            end

            ST_SW_WR: begin
               state     <= ST_DSYNC;
               idx       <= '0;
               icap_csib <= 1'b0;
               icap_i    <= to_icap(dsync_word(2'd0));
            end

            ST_DSYNC: begin
               if (idx == DSYNC_LAST) begin
                  state     <= ST_DONE;
                  icap_csib <= 1'b1;
                  icap_i    <= '0;
                  done      <= 1'b1;
               end else begin
                  idx    <= idx + 4'd1;
                  icap_i <= to_icap(dsync_word(idx[1:0] + 2'd1));
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   hapara_icap_rb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight[READ_LATENCY-1]),
      .push_data (to_icap(icap_o)),
      .pop       (m_valid_int && m.m_ready),
      .pop_data  (fifo_rdata),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign m_valid_int = !fifo_empty;
   assign m.m_valid   = m_valid_int;
   assign m.m_data    = fifo_rdata;

endmodule

// File: tb/tb_hapara_icap_readback.sv
// Directed bench for hapara_icap_readback with an ICAP read-latency model and write/read scoreboards.
`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         errors++; \
         $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
      end \
   end

module tb_hapara_icap_readback;
   localparam int LAT = 3;

`ifdef HAPARA_ICAP_BITSWAP_EN
   localparam logic [31:0] SYNC_EXP  = 32'h5599_AA66;
   localparam logic [31:0] FIRST_EXP = 32'h8000_0000;
`else
   localparam logic [31:0] SYNC_EXP  = 32'hAA99_5566;
   localparam logic [31:0] FIRST_EXP = 32'h0100_0000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] far = '0;
   logic [26:0] word_cnt = '0;
   logic        busy, done, icap_csib, icap_rdwrb;
   logic [31:0] icap_i, icap_o;

   hapara_icap_readback_if #(.DATA_WIDTH(32)) m_if ();

   hapara_icap_readback dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .far        (far),
      .word_cnt   (word_cnt),
      .busy       (busy),
      .done       (done),
      .icap_csib  (icap_csib),
      .icap_rdwrb (icap_rdwrb),
      .icap_i     (icap_i),
      .icap_o     (icap_o),
      .m          (m_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int pop_cnt = 0;
   int issue_cnt = 0;
   logic prev_rdwrb = 1'b0;
   logic [31:0] exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [31:0] pipe[LAT];
   int unsigned model_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] swap_exp(input logic [31:0] w);
`ifdef HAPARA_ICAP_BITSWAP_EN
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 8; i++)
            r[8*b + i] = w[8*b + 7 - i];
      return r;
`else
      return w;
`endif
   endfunction

   // ICAP read model: a word issued in cycle c is on icap_o in cycle c+LAT.
   always @(posedge clk) begin
      logic [31:0] w;
      if (!icap_csib && icap_rdwrb) begin
         w = 32'h0100_0000 + model_n * 32'h0001_0203;
         model_n++;
         exp_rd.push_back(swap_exp(w));
         pipe[0] <= w;
      end else begin
         pipe[0] <= 32'hBAD0_0000;
      end
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign icap_o = pipe[LAT-1];

   always @(negedge clk) begin
      logic [31:0] w;
      if (icap_rdwrb !== prev_rdwrb) `CHK("rdwrb_toggle_csib", icap_csib, 1'b1)
      prev_rdwrb = icap_rdwrb;
      if (!icap_csib && !icap_rdwrb) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL icap_wr_unexpected observed=%0h expected=none", icap_i);
         end else begin
            w = exp_wr.pop_front();
            `CHK("icap_wr", icap_i, w)
         end
      end
      if (!icap_csib && icap_rdwrb) issue_cnt++;
      if (done) done_cnt++;
      if (m_if.m_valid && m_if.m_ready) begin
         pop_cnt++;
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL m_data_unexpected observed=%0h expected=none", m_if.m_data);
         end else begin
            w = exp_rd.pop_front();
            `CHK("m_data", m_if.m_data, w)
         end
      end
   end

   task automatic push_expected(input logic [31:0] f, input logic [26:0] n);
      logic [31:0] seq[16];
      seq = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h2000_0000,
              32'h3000_8001, 32'h0000_0004, 32'h2000_0000, 32'h3000_2001,
              f,             32'h2800_6000, 32'h4800_0000 | {5'b0, n}, 32'h2000_0000,
              32'h3000_8001, 32'h0000_000D, 32'h2000_0000, 32'h2000_0000};
      for (int i = 0; i < 16; i++) exp_wr.push_back(swap_exp(seq[i]));
   endtask

   task automatic do_start(input logic [31:0] f, input logic [26:0] n, output int t0);
      push_expected(f, n);
      @(posedge clk); #1;
      start = 1'b1; far = f; word_cnt = n;
      @(negedge clk) t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      `CHK(tag, seen, 1'b1)
      @(negedge clk);
      `CHK("busy_after_done", busy, 1'b0)
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, base_issue, base_pop;
      logic found;
      m_if.m_ready = 1'b0;

      // Reset, with a start held high in the final reset cycle.
      repeat (2) @(posedge clk);
      #1 start = 1'b1; far = 32'h1111_1111; word_cnt = 27'd5;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      `CHK("rst_busy", busy, 1'b0)
      `CHK("rst_done", done, 1'b0)
      `CHK("rst_csib", icap_csib, 1'b1)
      `CHK("rst_rdwrb", icap_rdwrb, 1'b0)
      `CHK("rst_icap_i", icap_i, 32'h0)
      `CHK("rst_m_valid", m_if.m_valid, 1'b0)
      `CHK("rst_m_data", m_if.m_data, 32'h0)

      // A: four words at full throughput, plus a start while busy.
      m_if.m_ready = 1'b1;
      done_cnt = 0; base_issue = issue_cnt;
      do_start(32'h0040_0000, 27'd4, t0);
      @(negedge clk);
      `CHK("a_busy", busy, 1'b1)
      `CHK("a_hdr0", icap_i, 32'hFFFF_FFFF)
      @(negedge clk);
      `CHK("a_sync", icap_i, SYNC_EXP)
      @(posedge clk); #1 start = 1'b1; far = 32'hDEAD_BEEF; word_cnt = 27'd9;
      @(posedge clk); #1 start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (!icap_csib && icap_rdwrb) found = 1'b1;
      end
      `CHK("a_first_issue_cycle", cyc - t0, 14)
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (m_if.m_valid) found = 1'b1;
      end
      `CHK("a_first_valid_cycle", cyc - t0, 18)
      `CHK("a_first_data", m_if.m_data, FIRST_EXP)
      `CHK("a_issues", issue_cnt - base_issue, 4)
      wait_done(60, "a_done");
      `CHK("a_done_once", done_cnt, 1)
      `CHK("a_wr_left", exp_wr.size(), 0)
      `CHK("a_rd_left", exp_rd.size(), 0)

      // B: consumer stalled; issues must stop at FIFO_DEPTH, then drain all 40.
      m_if.m_ready = 1'b0;
      done_cnt = 0; base_issue = issue_cnt;
      do_start(32'h0123_4560, 27'd40, t0);
      repeat (60) @(negedge clk);
      `CHK("b_issues_stalled", issue_cnt - base_issue, 16)
      `CHK("b_valid_stalled", m_if.m_valid, 1'b1)
      `CHK("b_rd_pending", exp_rd.size(), 16)
      @(posedge clk); #1 m_if.m_ready = 1'b1;
      wait_done(200, "b_done");
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (!m_if.m_valid) found = 1'b1;
      end
      `CHK("b_drained", found, 1'b1)
      `CHK("b_issues", issue_cnt - base_issue, 40)
      `CHK("b_rd_left", exp_rd.size(), 0)
      `CHK("b_done_once", done_cnt, 1)
      `CHK("b_wr_left", exp_wr.size(), 0)

      // C: zero-length readback still runs header and DESYNC.
      done_cnt = 0; base_issue = issue_cnt;
      do_start(32'h0000_1234, 27'd0, t0);
      wait_done(60, "c_done");
      `CHK("c_issues", issue_cnt - base_issue, 0)
      `CHK("c_done_once", done_cnt, 1)
      `CHK("c_wr_left", exp_wr.size(), 0)

      // D: reset after two of eight words, then a clean readback.
      done_cnt = 0; base_pop = pop_cnt;
      do_start(32'h0080_0000, 27'd8, t0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (pop_cnt - base_pop >= 2) found = 1'b1;
      end
      `CHK("d_two_words", found, 1'b1)
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_rd.delete();
      exp_wr.delete();
      @(negedge clk);
      `CHK("d_rst_csib", icap_csib, 1'b1)
      `CHK("d_rst_rdwrb", icap_rdwrb, 1'b0)
      `CHK("d_rst_m_valid", m_if.m_valid, 1'b0)
      `CHK("d_rst_busy", busy, 1'b0)
      `CHK("d_rst_done_cnt", done_cnt, 0)
      base_issue = issue_cnt;
      do_start(32'h00C0_0000, 27'd3, t0);
      wait_done(80, "d_done");
      `CHK("d_issues", issue_cnt - base_issue, 3)
      `CHK("d_done_once", done_cnt, 1)
      `CHK("d_wr_left", exp_wr.size(), 0)
      `CHK("d_rd_left", exp_rd.size(), 0)

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hapara_icap_readback.md
# hapara_icap_readback

Configuration readback engine for the ICAPE2 port, and the read-direction counterpart of the burst ICAP write path. On a start request it issues the 7-series readback command sequence (sync, RCFG, FAR, FDRO read), switches the ICAP to read mode and streams the returned frame words out on a valid/ready interface. It finishes with a DESYNC. The ICAPE2 primitive sits in the enclosing wrapper; this block drives its pins.

## Interface
- DATA_WIDTH, 32: ICAP and stream word width. Only 32 (X32) is supported.
- FIFO_DEPTH, 16: output buffer depth in words. Power of two, at least READ_LATENCY+1.
- READ_LATENCY, 3: cycles from a read issue (csib=0, rdwrb=1) until icap_o is valid.
- clk  in  1  single clock for the block.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request. Ignored while busy.
- far  in  32  frame address register value, sampled when start is accepted.
- word_cnt  in  27  number of words to read back, sampled when start is accepted.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the DESYNC is complete.
- icap_csib  out  1  ICAP chip select, active-low.
- icap_rdwrb  out  1  ICAP direction: 0 = write, 1 = read.
- icap_i  out  32  word written to the ICAP.
- icap_o  in  32  word read from the ICAP.
- m_data  out  32  readback word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the word.

## Operation
States and transitions:
- IDLE -> HDR: on start.
- HDR -> SW_RD: after 12 write cycles.
- SW_RD -> READ: after 1 cycle.
- READ -> SW_WR: when all words are issued and received.
- SW_WR -> DSYNC: after 1 cycle.
- DSYNC -> DONE: after 4 write cycles.
- DONE -> IDLE: after 1 cycle.

HDR words, one per cycle with csib=0 and rdwrb=0:
- FFFFFFFF, AA995566, 20000000, 20000000
- 30008001, 00000004, 20000000, 30002001
- far, 28006000, 48000000|word_cnt, 20000000

Direction switches:
- SW_RD and SW_WR each hold csib=1 for one cycle while rdwrb changes. rdwrb never changes while csib=0.

READ:
- A read is issued (csib=0, rdwrb=1) only when remaining>0 and fifo_count+inflight < FIFO_DEPTH. Otherwise csib=1.
- inflight is a READ_LATENCY-deep valid shift register. Its output pushes icap_o into the FIFO.
- The FIFO pushes regardless of m_ready, because admission control guarantees space. It never overflows.
- m_valid = FIFO not empty. A pop happens on m_valid & m_ready.

DSYNC words: 30008001, 0000000D, 20000000, 20000000.

Other behaviour:
- word_cnt=0: READ is skipped (SW_RD -> SW_WR directly); the full sequence and done still occur.
- busy=1 from the cycle after start is accepted through the DONE cycle.
- DONE does not wait for the FIFO to drain. A new start is accepted once IDLE is reached, and new data appends behind words not yet drained.

## Timing
- Reset values:
  - busy=0, done=0, icap_csib=1, icap_rdwrb=0, icap_i=0.
  - m_valid=0, m_data=0.
  - FIFO and inflight cleared; state IDLE.
- Start accepted in cycle t: first header word appears on icap_i at t+1. The header occupies t+1 through t+12, SW_RD is at t+13 and the first read issue is at t+14.
- The first word reaches m_valid at t+14+READ_LATENCY+1 (one cycle for the FIFO write).
- With m_ready held high, reads issue every cycle at full throughput.
- Reset mid-operation returns the block to IDLE next cycle with outputs at reset values and FIFO contents discarded. The ICAP may be left synced; software recovers with a new readback or a write-path DESYNC.
- start in the same cycle as rst is ignored.

## Configuration
- HAPARA_ICAP_BITSWAP_EN defined: bits within each byte are reversed on icap_i (all header, FAR and DSYNC words) and on icap_o before the FIFO. Software then sees natural bitstream order.
- Not defined: words pass unmodified, so software supplies and receives ICAP-native bit order. This matches the write path's raw-data convention.

## Structure
- Package hapara_icap_pkg holds:
  - the state enum;
  - the constants ICAP_DUMMY, ICAP_SYNC, ICAP_NOOP, ICAP_WR_CMD, ICAP_CMD_RCFG, ICAP_CMD_DESYNC, ICAP_WR_FAR, ICAP_RD_FDRO, ICAP_T2_RD;
  - HDR_LEN=12 and DSYNC_LEN=4.
- One sub-module, hapara_icap_rb_fifo: a synchronous FIFO with FIFO_DEPTH and DATA_WIDTH parameters, push/pop, and a count output.

## Test plan
- Reset, then start with far=00400000 and word_cnt=4, no bitswap, m_ready=1 -> icap_i carries the 12 header words in order with word 10 = 48000004. Four read issues follow, the 4 model words appear on m_data in order, then the DSYNC words, then done pulses once and busy falls.
- m_ready=0 with word_cnt=40 and FIFO_DEPTH=16 -> issues stop once fifo_count+inflight=16 and no word is lost. Releasing m_ready drains all 40 words in order.
- word_cnt=0 -> the 12 header words, no cycle with rdwrb=1 and csib=0, the 4 DSYNC words, then done.
- rst asserted during READ after 2 of 8 words -> next cycle csib=1, rdwrb=0, m_valid=0, busy=0. A new start then performs a full clean sequence.
- Check over all scenarios: rdwrb only toggles in cycles where csib=1, and a start while busy is ignored.
- Build with HAPARA_ICAP_BITSWAP_EN -> the first icap_i word is FFFFFFFF and the sync word appears as 5599AA66. A model word 01000000 returns on m_data as 80000000.
